// File: rtl/lane_serializer.sv
// lane_serializer: per-lane byte FIFO feeding an MSB-first serializer.
// One bit leaves per clk_8f cycle; a byte boundary is every 8th edge. When no
// data byte is available at a boundary, the COM character is sent instead.
// Optional build macro LANE_SER_BC_SYNC_EN: after reset, send exactly four COM
// bytes before the first data byte is allowed out of the FIFO.
module lane_serializer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  COM_CHAR   = 8'hBC
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] lane_in,
    input  logic       valid_in,
    output logic       in_ready,
    output logic       data_out,
    output logic       frame_start,
    output logic       is_com,
    output logic       overflow
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_shreg;
    logic [2:0]  r_bit_cnt;
    logic        r_is_com;
    logic        r_overflow;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_boundary;
    logic        w_active;
    logic        w_pop;

    // Pointers carry one extra wrap bit: equal -> empty, differ only in MSB -> full.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push     = valid_in && !w_full;
    assign w_boundary = (r_bit_cnt == 3'd7);
    // Pop decision uses pre-edge occupancy, so a same-edge push is never bypassed.
    assign w_pop      = w_boundary && w_active && !w_empty;

`ifdef LANE_SER_BC_SYNC_EN
    typedef enum logic {
        ST_SYNC,
        ST_ACTIVE
    } state_t;

    state_t     r_state;
    logic [1:0] r_sync_cnt;

    // Startup FSM: count COM loads in SYNC, go ACTIVE on the edge of the 4th.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_state    <= ST_SYNC;
            r_sync_cnt <= 2'd0;
        end else if (w_boundary && (r_state == ST_SYNC)) begin
            if (r_sync_cnt == 2'd3) begin
                r_state <= ST_ACTIVE;
            end
            r_sync_cnt <= r_sync_cnt + 2'd1;
        end
    end

    assign w_active = (r_state == ST_ACTIVE);
`else
    assign w_active = 1'b1;
`endif

    // FIFO storage; contents are logically discarded by the pointer reset.
    always_ff @(posedge clk_8f) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= lane_in;
        end
    end

    // FIFO pointers and sticky overflow flag for bytes dropped while full.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (valid_in && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Serializer: load data or COM at a boundary, otherwise shift left.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_bit_cnt <= 3'd7;
            r_shreg   <= 8'h00;
            r_is_com  <= 1'b0;
        end else if (w_boundary) begin
            r_bit_cnt <= 3'd0;
            if (w_pop) begin
                r_shreg  <= r_mem[r_rd_ptr[AW-1:0]];
                r_is_com <= 1'b0;
            end else begin
                r_shreg  <= COM_CHAR;
                r_is_com <= 1'b1;
            end
        end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shreg   <= {r_shreg[6:0], 1'b0};
        end
    end

    assign in_ready    = !w_full;
    assign data_out    = r_shreg[7];
    assign frame_start = (r_bit_cnt == 3'd0) && !reset;
    assign is_com      = r_is_com;
    assign overflow    = r_overflow;

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Per-lane parallel-to-serial stage directly downstream of the byte-striping block in the PHY transmit path. It takes one lane's byte stream (data plus valid), buffers it in a small FIFO, and shifts it out MSB-first, one bit per `clk_8f` cycle. When no data byte is ready at a byte boundary, it sends the COM idle character 0xBC. One instance is used per lane.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: input FIFO entries; must be a power of 2 and at least 2.
- `COM_CHAR`, default 8'hBC: idle/sync character.

Ports:
- `clk_8f`  in  1: single clock. Every input and output is synchronous to its rising edge.
- `reset`  in  1: synchronous, active-high.
- `lane_in`  in  8: byte from the striping stage.
- `valid_in`  in  1: `lane_in` is valid this cycle.
- `in_ready`  out  1: FIFO can accept a byte; equals `!fifo_full`.
- `data_out`  out  1: serial bit, driven as `shreg[7]`.
- `frame_start`  out  1: high while `data_out` carries bit 7 of a byte.
- `is_com`  out  1: high for all 8 bits of a COM byte.
- `overflow`  out  1: sticky; set when a byte is dropped because the FIFO is full.

## Operation
- Push: on a rising edge with `valid_in && in_ready`, `lane_in` is written to the FIFO.
  - `valid_in` while full: the byte is dropped and `overflow` is set to 1. `overflow` is cleared only by `reset`.
- Bit counter `bit_cnt` (3 bits):
  - Byte boundary = an edge with `bit_cnt==7`. At a boundary, `shreg` loads, `bit_cnt` goes to 0, and `is_com` is updated.
  - On any other edge, `shreg <= shreg<<1` and `bit_cnt` increments.
- Load source at a boundary:
  - State ACTIVE and FIFO not empty: pop the head entry and load it; `is_com` = 0.
  - Otherwise: load `COM_CHAR`; `is_com` = 1.
- No bypass. A byte pushed on the same edge as a boundary, into an empty FIFO, is not loaded at that edge; it waits for the next boundary. Push and pop on the same edge are both honoured, and the occupancy count is unchanged.
- FIFO uses wrap-around read/write pointers with `log2(FIFO_DEPTH)+1` bits. Full and empty are decided from the extra MSB.
- State machine (2 states):
  - SYNC: every boundary loads COM and no pops occur; pushes are still accepted.
  - ACTIVE: normal operation.
- `frame_start` = (`bit_cnt==0`) and not in reset.

## Timing
- Reset values:
  - `bit_cnt`=7, `shreg`=0, FIFO empty, `overflow`=0, `is_com`=0.
  - `data_out`=0, `frame_start`=0, `in_ready`=1.
  - State = SYNC if `BC_SYNC_EN` is defined, else ACTIVE.
- First edge with `reset` low is a boundary. After it, `data_out` presents bit 7 of the first byte and `frame_start`=1.
- Byte period: exactly 8 cycles; boundaries occur every 8th edge after the first one.
- Minimum latency: a push at edge E reaches `data_out` (bit 7) after the next boundary B > E, i.e. 1 to 8 cycles later with an empty FIFO.
- `reset` asserted mid-byte:
  - The partial byte is abandoned and FIFO contents are discarded.
  - On the next edge, all outputs take their reset values.

## Configuration
- `LANE_SER_BC_SYNC_EN` defined:
  - Reset enters SYNC.
  - Exactly 4 COM bytes are sent; the transition to ACTIVE occurs on the edge of the 4th COM load.
  - The first data pop is at the 5th boundary.
- Not defined: reset enters ACTIVE directly, and the SYNC state and its 2-bit COM counter are absent.

## Test plan
- Idle after reset, macro off, no `valid_in`: `data_out` = 1,0,1,1,1,1,0,0 repeating; `is_com`=1; `frame_start` every 8 cycles.
- Push 0xA5 while the FIFO is empty:
  - At the next boundary, `data_out` = 1,0,1,0,0,1,0,1 and `is_com`=0.
  - The following byte is COM.
- Push 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles, with `FIFO_DEPTH`=4 and no boundary in between:
  - `in_ready` drops after the 4th push.
  - 0x05 is dropped and `overflow`=1.
  - Output is 0x01 through 0x04 in order, followed by COM.
- Push on the same edge as a boundary, into an empty FIFO: COM is sent in that slot and the data byte is sent in the next slot.
- Macro on, push 0x3C right after reset: four COM bytes are sent, then 0x3C starts at the 5th boundary.
- Assert `reset` at `bit_cnt`=3 while two bytes are queued:
  - `data_out`=0 and `overflow`=0; the queued bytes are never transmitted.
  - Restart begins with COM (macro off) at the first boundary after release.
